// File: rtl/dqs_dly_sequencer.sv
// rtl/dqs_dly_sequencer.sv - DQS delay-tap load/sweep sequencer with per-lane edge search
module dqs_dly_sequencer #(
    parameter int NUM_LANES     = 4,
    parameter int DLY_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_mode,
    input  logic [3:0]           cmd_lane,
    input  logic [DLY_WIDTH-1:0] cmd_start,
    input  logic [DLY_WIDTH-1:0] cmd_end,
    input  logic [DLY_WIDTH-1:0] cmd_step,
    input  logic [NUM_LANES-1:0] lane_in,
    output logic [DLY_WIDTH-1:0] dly_data,
    output logic [NUM_LANES-1:0] ld,
    output logic                 set,
    output logic                 result_valid,
    output logic [DLY_WIDTH-1:0] result_value,
    output logic                 result_found,
    output logic                 result_err
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SET,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               state_q;
    logic                 sweep_q;
    logic [3:0]           lane_q;
    logic [DLY_WIDTH-1:0] start_q;
    logic [DLY_WIDTH-1:0] end_q;
    logic [DLY_WIDTH-1:0] step_q;
    logic [DLY_WIDTH-1:0] code_q;
    logic                 first_q;
    logic                 ref_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_LANES-1:0] sync1_q;
    logic [NUM_LANES-1:0] sync2_q;
    logic [NUM_LANES-1:0] ld_q;
    logic                 set_q;
    logic [DLY_WIDTH-1:0] dly_q;
    logic                 rv_q;
    logic [DLY_WIDTH-1:0] rval_q;
    logic                 rfound_q;
    logic                 rerr_q;

    logic                 cmd_bad_d;
    logic [NUM_LANES-1:0] cmd_mask_d;
    logic [NUM_LANES-1:0] run_mask_d;
    logic                 sample_bit_d;
    logic [DLY_WIDTH:0]   next_code_d;
    logic                 more_d;

    assign cmd_ready    = (state_q == S_IDLE);
    assign dly_data     = dly_q;
    assign ld           = ld_q;
    assign set          = set_q;
    assign result_valid = rv_q;
    assign result_value = rval_q;
    assign result_found = rfound_q;
    assign result_err   = rerr_q;

    // Command legality; one extra bit on the lane compare so NUM_LANES=16 works
    assign cmd_bad_d = (cmd_mode == 2'd3) || ({1'b0, cmd_lane} >= 5'(NUM_LANES));

    // Next tap computed one bit wider so a step past the top tap ends the sweep instead of wrapping
    assign next_code_d = {1'b0, code_q} + {1'b0, step_q};
    assign more_d      = (next_code_d <= {1'b0, end_q});

    // Load masks for a new command and for a running sweep, plus the selected lane's synchronised level
    always_comb begin
        cmd_mask_d   = '0;
        run_mask_d   = '0;
        sample_bit_d = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cmd_mode == 2'd1 || cmd_lane == 4'(i)) begin
                cmd_mask_d[i] = 1'b1;
            end
            if (lane_q == 4'(i)) begin
                run_mask_d[i] = 1'b1;
                sample_bit_d  = sync2_q[i];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous received DQS levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= lane_in;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer FSM with registered strobes and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sweep_q  <= 1'b0;
            lane_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            step_q   <= '0;
            code_q   <= '0;
            first_q  <= 1'b0;
            ref_q    <= 1'b0;
            cnt_q    <= '0;
            ld_q     <= '0;
            set_q    <= 1'b0;
            dly_q    <= '0;
            rv_q     <= 1'b0;
            rval_q   <= '0;
            rfound_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            ld_q  <= '0;
            set_q <= 1'b0;
            rv_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sweep_q <= (cmd_mode == 2'd2);
                        lane_q  <= cmd_lane;
                        start_q <= cmd_start;
                        end_q   <= cmd_end;
                        step_q  <= (cmd_step == '0) ? DLY_WIDTH'(1) : cmd_step;
                        code_q  <= cmd_start;
                        first_q <= 1'b1;
                        if (cmd_bad_d) begin
                            state_q  <= S_DONE;
                            rv_q     <= 1'b1;
                            rval_q   <= '0;
                            rfound_q <= 1'b0;
                            rerr_q   <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            ld_q    <= cmd_mask_d;
                            dly_q   <= cmd_start;
                        end
                    end
                end
                S_LOAD: begin
                    state_q <= S_SET;
                    set_q   <= 1'b1;
                end
                S_SET: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= '0;
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        if (sweep_q) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            state_q  <= S_DONE;
                            rv_q     <= 1'b1;
                            rval_q   <= start_q;
                            rfound_q <= 1'b0;
                            rerr_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        ref_q <= sample_bit_d;
                    end
                    if (!first_q && (sample_bit_d != ref_q)) begin
                        state_q  <= S_DONE;
                        rv_q     <= 1'b1;
                        rval_q   <= code_q;
                        rfound_q <= 1'b1;
                        rerr_q   <= 1'b0;
                    end else if (more_d) begin
                        state_q <= S_LOAD;
                        code_q  <= next_code_d[DLY_WIDTH-1:0];
                        dly_q   <= next_code_d[DLY_WIDTH-1:0];
                        ld_q    <= run_mask_d;
                    end else begin
                        state_q  <= S_DONE;
                        rv_q     <= 1'b1;
                        rval_q   <= code_q;
                        rfound_q <= 1'b0;
                        rerr_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dqs_dly_sequencer.md
DQS_DLY_SEQUENCER -- requirements
Module: dqs_dly_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of delay lanes (1..16).
REQ-002 SHALL have parameter DLY_WIDTH, default 5, delay tap code width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, wait cycles after set before sampling or completion (>=3).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_mode, input, 2, command mode: 0 load one lane, 1 load all lanes, 2 sweep one lane, 3 reserved.
REQ-009 SHALL have port cmd_lane, input, 4, target lane.
REQ-010 SHALL have port cmd_start, input, DLY_WIDTH, load value or sweep start.
REQ-011 SHALL have port cmd_end, input, DLY_WIDTH, sweep end (inclusive).
REQ-012 SHALL have port cmd_step, input, DLY_WIDTH, sweep increment (0 treated as 1).
REQ-013 SHALL have port lane_in, input, NUM_LANES, asynchronous per-lane received DQS levels.
REQ-014 SHALL have port dly_data, output, DLY_WIDTH, shared delay code bus to all lanes.
REQ-015 SHALL have port ld, output, NUM_LANES, per-lane one-cycle load strobe.
REQ-016 SHALL have port set, output, 1, one-cycle apply strobe common to all lanes.
REQ-017 SHALL have port result_valid, output, 1, one-cycle completion pulse.
REQ-018 SHALL have ports result_value (output, DLY_WIDTH), result_found (output, 1) and result_err (output, 1), held until the next completion.

Function
REQ-019 SHALL implement states IDLE, LOAD, SET, SETTLE, SAMPLE, DONE; cmd_ready SHALL be high only in IDLE.
REQ-020 SHALL register the cmd_* fields on acceptance; later changes on the inputs SHALL have no effect.
REQ-021 SHALL, on acceptance of mode 3 or cmd_lane >= NUM_LANES, go directly to DONE with result_err=1, result_found=0, and no ld or set strobe.
REQ-022 SHALL, in LOAD (1 cycle), drive dly_data with the current code and assert ld[cmd_lane] (mode 0/2) or all ld bits (mode 1).
REQ-023 SHALL, in SET (1 cycle), assert set with dly_data held.
REQ-024 SHALL, in SETTLE, count SETTLE_CYCLES cycles, then enter SAMPLE (mode 2) or DONE (mode 0/1).
REQ-025 SHALL synchronise lane_in through a 2-flop synchroniser per lane.
REQ-026 SHALL, on the first SAMPLE of a sweep, store the synchronised lane bit as the reference level.
REQ-027 SHALL, on later samples, go to DONE with result_found=1 and result_value = current code if the sample differs from the reference.
REQ-028 SHALL otherwise compute next = current + step at DLY_WIDTH+1 bits, and return to LOAD with code = next when next <= cmd_end.
REQ-029 SHALL otherwise go to DONE with result_found=0 and result_value = last tested code; this covers tap-range overflow.
REQ-030 SHALL treat cmd_start > cmd_end in a sweep as a single-point test: one sample, result_found=0.
REQ-031 SHALL, for mode 0/1, set result_value=cmd_start and result_found=0 in DONE.
REQ-032 SHALL pulse result_valid for exactly 1 cycle in DONE, then return to IDLE.
REQ-033 SHALL make a single-lane load take 2+SETTLE_CYCLES+1 cycles from acceptance to result_valid.

Reset
REQ-034 SHALL, while rst_n is low, immediately force state IDLE, cmd_ready=1, and ld, set, dly_data, result_valid, result_value, result_found, result_err and the synchronisers to 0.
REQ-035 SHALL abandon any in-progress command on reset assertion mid-operation, with no further strobes and no result_valid.

Verification
REQ-036 SHALL cover: mode 0, lane 2, start=13, SETTLE_CYCLES=4 -> ld=0100 then set, dly_data=13, result_valid 7 cycles after acceptance.
REQ-037 SHALL cover: mode 1, start=7 -> ld=1111 for one cycle, then set, result_found=0, result_value=7.
REQ-038 SHALL cover: mode 2, lane 1, start=0, end=31, step=2, lane_in[1] rising while code=10 is loaded -> result_found=1, result_value=10.
REQ-039 SHALL cover: mode 2, start=28, end=31, step=3, lane_in constant -> codes 28 and 31 tested, result_found=0, result_value=31, no wrap to 2.
REQ-040 SHALL cover: cmd_lane=5 with NUM_LANES=4 -> result_err=1, ld=0 and set=0 throughout.
REQ-041 SHALL cover: rst_n low during SETTLE of a sweep -> all outputs 0 asynchronously, no result_valid, cmd_ready=1 after release.
